// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT core.
// FSM encoding and default length-derived widths.
package fft_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } state_t;

  localparam int FFT_N  = 32;
  localparam int FFT_AW = $clog2(FFT_N);
  localparam int FFT_SW = ($clog2(FFT_AW) > 1) ? $clog2(FFT_AW) : 1;

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register modelling butterfly latency.
// MSB of each word is its valid bit.
module fft_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];
  logic             live;

  // shift one slot per cycle, never stalls
  always_comb begin
    pipe_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  // pipeline storage, cleared so reset drops in-flight work
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        pipe_q[i] <= pipe_d[i];
    end
  end

  // empty once nothing remains beyond this cycle's write-back
  always_comb begin
    live = in_data[WIDTH-1];
    for (int i = 0; i < DEPTH - 1; i++)
      live = live | pipe_q[i][WIDTH-1];
    empty = ~live;
  end

  assign out_data = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Butterfly address sequencer for the in-place radix-2 FFT.
// Issues reads per stage, mirrors them to write-back after PIPE_LAT.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N             = FFT_N,
  parameter int address_width = $clog2(N),
  parameter int stage_width   =
    ($clog2($clog2(N)) > 1) ? $clog2($clog2(N)) : 1,
  parameter int PIPE_LAT      = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     load_done,
  input  logic                     bf_ready,
  output logic                     rd_en,
  output logic [address_width-1:0] rd_addr1,
  output logic [address_width-1:0] rd_addr2,
  output logic [address_width-2:0] tw_addr,
  output logic [stage_width-1:0]   stage,
  output logic                     wr_en,
  output logic [address_width-1:0] wr_addr1,
  output logic [address_width-1:0] wr_addr2,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = address_width;
  localparam int SW = stage_width;
  localparam int DW = 2 * AW + 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(AW - 1);
  localparam logic [AW-2:0] LAST_BF    = '1;

  state_t          state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [AW-2:0]   b_q, b_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_addr1_q, rd_addr1_d;
  logic [AW-1:0]   rd_addr2_q, rd_addr2_d;
  logic [AW-2:0]   tw_q, tw_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [AW-1:0]   b_ext, span, pos, grp;
  logic [AW-1:0]   a1, a2, tw_full;
  logic [DW-1:0]   dl_out;
  logic            dl_empty;

  // operand and twiddle addresses for (stage, b)
  always_comb begin
    b_ext   = AW'(b_q);
    span    = AW'(1) << stage_q;
    pos     = b_ext & (span - AW'(1));
    grp     = b_ext >> stage_q;
    a1      = ((grp << stage_q) << 1) | pos;
    a2      = a1 | span;
    tw_full = pos << (LAST_STAGE - stage_q);
  end

  // next state, counters and registered outputs
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    b_d        = b_q;
    rd_en_d    = 1'b0;
    rd_addr1_d = rd_addr1_q;
    rd_addr2_d = rd_addr2_q;
    tw_d       = tw_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WAIT_LOAD;
      end
      S_WAIT_LOAD: begin
        if (load_done) begin
          state_d = S_ISSUE;
          stage_d = '0;
          b_d     = '0;
        end
      end
      S_ISSUE: begin
        if (bf_ready) begin
          rd_en_d    = 1'b1;
          rd_addr1_d = a1;
          rd_addr2_d = a2;
          tw_d       = tw_full[AW-2:0];
          if (b_q == LAST_BF) begin
            b_d     = '0;
            state_d = S_DRAIN;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (dl_empty) begin
          if (stage_q == LAST_STAGE) begin
            state_d = S_FINISH;
          end else begin
            stage_d = stage_q + 1'b1;
            b_d     = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      stage_q    <= '0;
      b_q        <= '0;
      rd_en_q    <= 1'b0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      tw_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      b_q        <= b_d;
      rd_en_q    <= rd_en_d;
      rd_addr1_q <= rd_addr1_d;
      rd_addr2_q <= rd_addr2_d;
      tw_q       <= tw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  fft_delay_line #(
    .WIDTH (DW),
    .DEPTH (PIPE_LAT)
  ) u_dl (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  ({rd_en_q, rd_addr1_q, rd_addr2_q}),
    .out_data (dl_out),
    .empty    (dl_empty)
  );

  assign rd_en    = rd_en_q;
  assign rd_addr1 = rd_addr1_q;
  assign rd_addr2 = rd_addr2_q;
  assign tw_addr  = tw_q;
  assign stage    = stage_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_en    = dl_out[DW-1];
  assign wr_addr1 = dl_out[DW-2:AW];
  assign wr_addr2 = dl_out[AW-1:0];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer, N=8, PIPE_LAT=4.
// Expected issues come from a fixed table; write-backs from observed issues.
module tb_fft_stage_sequencer;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int SW = 2;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          load_done;
  logic          bf_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [AW-2:0] tw_addr;
  logic [SW-1:0] stage;
  logic          wr_en;
  logic [AW-1:0] wr_addr1, wr_addr2;
  logic          busy, done;

  fft_stage_sequencer #(
    .N             (N),
    .address_width (AW),
    .stage_width   (SW),
    .PIPE_LAT      (PL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .load_done (load_done),
    .bf_ready  (bf_ready),
    .rd_en     (rd_en),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .tw_addr   (tw_addr),
    .stage     (stage),
    .wr_en     (wr_en),
    .wr_addr1  (wr_addr1),
    .wr_addr2  (wr_addr2),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct { int a1; int a2; int tw; int st; } iss_t;
  typedef struct { int c; int a1; int a2; } wb_t;

  int tab [12][3] = '{
    '{0, 1, 0}, '{2, 3, 0}, '{4, 5, 0}, '{6, 7, 0},
    '{0, 2, 0}, '{1, 3, 2}, '{4, 6, 0}, '{5, 7, 2},
    '{0, 4, 0}, '{1, 5, 1}, '{2, 6, 2}, '{3, 7, 3}
  };

  iss_t exp_q [$];
  wb_t  wb_q  [$];
  iss_t e;
  wb_t  w;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt, wr_cnt, wr_after;
  int first_rd, done_cyc;
  bit done_seen, st1_seen;
  bit bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // random or steady butterfly readiness
  initial begin
    bf_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bf_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: compare issues to table, write-backs to issues
  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      if (rd_cnt > 0 && rd_cnt % (N / 2) == 0)
        chk("stage_order", wb_q.size(), 0);
      if (rd_cnt == 0) first_rd = cyc;
      if (exp_q.size() == 0) begin
        chk("rd_extra", rd_en, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_addr1", rd_addr1, e.a1);
        chk("rd_addr2", rd_addr2, e.a2);
        chk("tw_addr", tw_addr, e.tw);
        chk("stage", stage, e.st);
      end
      if (stage == 1) st1_seen = 1'b1;
      w.c  = cyc;
      w.a1 = rd_addr1;
      w.a2 = rd_addr2;
      wb_q.push_back(w);
      rd_cnt++;
    end
    if (wr_en === 1'b1) begin
      wr_cnt++;
      wr_after++;
      if (wb_q.size() == 0) begin
        chk("wr_extra", wr_en, 0);
      end else begin
        w = wb_q.pop_front();
        chk("wr_lat", cyc - w.c, PL);
        chk("wr_addr1", wr_addr1, w.a1);
        chk("wr_addr2", wr_addr2, w.a2);
      end
    end
    if (done === 1'b1) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic prime();
    exp_q.delete();
    wb_q.delete();
    rd_cnt    = 0;
    wr_cnt    = 0;
    done_seen = 1'b0;
    st1_seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      iss_t x;
      x.a1 = tab[i][0];
      x.a2 = tab[i][1];
      x.tw = tab[i][2];
      x.st = i / 4;
      exp_q.push_back(x);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !done_seen; i++)
      @(posedge clk);
    chk("done_seen", done_seen, 1);
  endtask

  task automatic run(input bit use_bp);
    prime();
    load_done = 1'b1;
    bp = use_bp;
    pulse_start();
    wait_done(600);
    bp = 1'b0;
    if (!use_bp) chk("xform_time", done_cyc - first_rd, 27);
    chk("issues_left", exp_q.size(), 0);
    chk("wr_count", wr_cnt, 12);
    @(posedge clk);
    #1 chk("busy_fall", busy, 0);
  endtask

  initial begin
    int bad;
    int n;
    reset_n   = 1'b0;
    start     = 1'b0;
    load_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {rd_en, wr_en, busy, done, stage, rd_addr1,
                    rd_addr2, tw_addr, wr_addr1, wr_addr2}, 0);
    reset_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if ({busy, rd_en, wr_en, done} !== 4'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    run(1'b0);
    run(1'b1);

    prime();
    load_done = 1'b0;
    pulse_start();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) bad++;
    end
    chk("gate_busy", bad, 0);
    chk("gate_no_rd", rd_cnt, 0);
    load_done = 1'b1;
    n = 0;
    for (int i = 1; i <= 6 && n == 0; i++) begin
      @(posedge clk);
      #1;
      if (rd_en === 1'b1) n = i;
    end
    chk("load_lat_le2", (n >= 1 && n <= 2), 1);
    wait_done(200);
    chk("gate_wr_count", wr_cnt, 12);

    prime();
    pulse_start();
    for (int i = 0; i < 200 && !st1_seen; i++)
      @(posedge clk);
    chk("stage1_seen", st1_seen, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out", {rd_en, wr_en, busy, done, stage, rd_addr1,
                       rd_addr2, tw_addr, wr_addr1, wr_addr2}, 0);
    exp_q.delete();
    wb_q.delete();
    wr_after = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("wr_after_rst", wr_after, 0);
    run(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
